// File: rtl/fpmul_pkg.sv
// Shared constants for the FP multiplier sharing block: IEEE-754 single
// field layout and the requester-index width helper.
package fpmul_pkg;

    localparam int FP_W     = 32;
    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;

    // Index width for n requesters; never zero so a single requester still has a tag bit.
    function automatic int idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpmul_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr,
// wrapping. Returns a one-hot grant and its encoded index.
module rr_arbiter import fpmul_pkg::*; #(
    parameter int NREQ = 2,
    parameter int IW   = idw(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_gidx
);

    logic w_found;

    // First pass covers ptr..NREQ-1, second pass the wrapped range 0..ptr-1.
    always_comb begin
        o_grant = '0;
        o_gidx  = '0;
        w_found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && i_elig[j] && (j >= int'(i_ptr))) begin
                w_found    = 1'b1;
                o_grant[j] = 1'b1;
                o_gidx     = IW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && i_elig[j] && (j < int'(i_ptr))) begin
                w_found    = 1'b1;
                o_grant[j] = 1'b1;
                o_gidx     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fpmul_share_ctrl.sv
// Shares one pipelined FP multiplier between NREQ requesters: round-robin
// issue, tag pipe matched to multiplier latency, one response slot each.
module fpmul_share_ctrl import fpmul_pkg::*; #(
    parameter int NREQ    = 2,
    parameter int MUL_LAT = 2,
    parameter int FP_W    = fpmul_pkg::FP_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [NREQ*FP_W-1:0] resp_data,
    output logic [FP_W-1:0]      mul_op1,
    output logic [FP_W-1:0]      mul_op2,
    output logic                 mul_in_valid,
    input  logic [FP_W-1:0]      mul_result,
    output logic                 idle
);

    localparam int IW = idw(NREQ);

    logic [NREQ-1:0]      r_busy;
    logic [IW-1:0]        r_ptr;
    logic [FP_W-1:0]      r_mul_op1;
    logic [FP_W-1:0]      r_mul_op2;
    logic                 r_mul_in_valid;
    logic [IW-1:0]        r_iss_id;
    logic [NREQ-1:0]      r_resp_valid;
    logic [NREQ*FP_W-1:0] r_resp_data;

    logic [NREQ-1:0]      w_elig;
    logic [NREQ-1:0]      w_grant;
    logic [IW-1:0]        w_gidx;
    logic                 w_any;
    logic [NREQ-1:0]      w_resp_hs;
    logic                 w_cap_v;
    logic [IW-1:0]        w_cap_id;

    // A busy requester cannot issue, so its response slot is always free on capture.
    assign w_elig    = req_valid & ~r_busy;
    assign w_any     = |w_grant;
    assign w_resp_hs = r_resp_valid & resp_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_gidx  (w_gidx)
    );

    // The issue tag rides with mul_in_valid; MUL_LAT further stages align it with mul_result.
    generate
        if (MUL_LAT == 0) begin : g_nopipe
            assign w_cap_v  = r_mul_in_valid;
            assign w_cap_id = r_iss_id;
        end else begin : g_pipe
            logic [MUL_LAT-1:0] r_tv;
            logic [IW-1:0]      r_tid [MUL_LAT];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_tv <= '0;
                    for (int k = 0; k < MUL_LAT; k++) begin
                        r_tid[k] <= '0;
                    end
                end else begin
                    r_tv[0]  <= r_mul_in_valid;
                    r_tid[0] <= r_iss_id;
                    for (int k = 1; k < MUL_LAT; k++) begin
                        r_tv[k]  <= r_tv[k-1];
                        r_tid[k] <= r_tid[k-1];
                    end
                end
            end

            assign w_cap_v  = r_tv[MUL_LAT-1];
            assign w_cap_id = r_tid[MUL_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy         <= '0;
            r_ptr          <= '0;
            r_mul_op1      <= '0;
            r_mul_op2      <= '0;
            r_mul_in_valid <= 1'b0;
            r_iss_id       <= '0;
            r_resp_valid   <= '0;
            r_resp_data    <= '0;
        end else begin
            r_busy         <= (r_busy & ~w_resp_hs) | w_grant;
            r_mul_in_valid <= w_any;
            if (w_any) begin
                r_mul_op1 <= req_a[int'(w_gidx)*FP_W +: FP_W];
                r_mul_op2 <= req_b[int'(w_gidx)*FP_W +: FP_W];
                r_iss_id  <= w_gidx;
                if (w_gidx == IW'(NREQ-1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gidx + 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (w_resp_hs[i]) begin
                    r_resp_valid[i] <= 1'b0;
                end
                if (w_cap_v && (int'(w_cap_id) == i)) begin
                    r_resp_valid[i]              <= 1'b1;
                    r_resp_data[i*FP_W +: FP_W] <= mul_result;
                end
            end
        end
    end

    assign req_ready    = w_grant;
    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_resp_data;
    assign mul_op1      = r_mul_op1;
    assign mul_op2      = r_mul_op2;
    assign mul_in_valid = r_mul_in_valid;
    assign idle         = ~|r_busy;

endmodule

// File: tb/tb_fpmul_share_ctrl.sv
// Bench for fpmul_share_ctrl: directed latency/arbitration/reset cases on a
// MUL_LAT=2 instance and a MUL_LAT=0 instance, then randomized traffic.
module tb_fpmul_share_ctrl;

  localparam int LAT = 2;

  logic clk;
  logic reset;

  // MUL_LAT=2 instance
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [63:0] req_a, req_b, resp_data;
  logic [31:0] mul_op1, mul_op2, mul_result;
  logic        mul_in_valid, idle;

  // MUL_LAT=0 instance
  logic [1:0]  z_req_valid, z_req_ready, z_resp_valid, z_resp_ready;
  logic [63:0] z_req_a, z_req_b, z_resp_data;
  logic [31:0] z_mul_op1, z_mul_op2, z_mul_result;
  logic        z_mul_in_valid, z_idle;

  int n_cmp = 0;
  int n_err = 0;

  // Truncating single-precision multiply for normal operands (external multiplier stand-in).
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          e;
    logic [22:0] m;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - fpmul_pkg::EXP_BIAS;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(100, 154));
    return r;
  endfunction

  fpmul_share_ctrl #(.NREQ(2), .MUL_LAT(LAT), .FP_W(32)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .mul_op1      (mul_op1),
    .mul_op2      (mul_op2),
    .mul_in_valid (mul_in_valid),
    .mul_result   (mul_result),
    .idle         (idle)
  );

  fpmul_share_ctrl #(.NREQ(2), .MUL_LAT(0), .FP_W(32)) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (z_req_valid),
    .req_ready    (z_req_ready),
    .req_a        (z_req_a),
    .req_b        (z_req_b),
    .resp_valid   (z_resp_valid),
    .resp_ready   (z_resp_ready),
    .resp_data    (z_resp_data),
    .mul_op1      (z_mul_op1),
    .mul_op2      (z_mul_op2),
    .mul_in_valid (z_mul_in_valid),
    .mul_result   (z_mul_result),
    .idle         (z_idle)
  );

  // Multiplier models: two-stage pipe for u_dut, combinational for u_dut0.
  logic [31:0] m_s0, m_s1;
  always @(posedge clk) begin
    m_s0 <= fmul_model(mul_op1, mul_op2);
    m_s1 <= m_s0;
  end
  assign mul_result   = m_s1;
  assign z_mul_result = fmul_model(z_mul_op1, z_mul_op2);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_valid    = '0;
    resp_ready   = '0;
    req_a        = '0;
    req_b        = '0;
    z_req_valid  = '0;
    z_resp_ready = '0;
    z_req_a      = '0;
    z_req_b      = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 2'b00);
    chk({tag, "_resp_valid"}, resp_valid, 2'b00);
    chk({tag, "_resp_data"}, resp_data, 64'h0);
    chk({tag, "_mul_op1"}, mul_op1, 32'h0);
    chk({tag, "_mul_op2"}, mul_op2, 32'h0);
    chk({tag, "_mul_in_valid"}, mul_in_valid, 1'b0);
    chk({tag, "_idle"}, idle, 1'b1);
  endtask

  // ---------------- scoreboard state for the random phase ----------------
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  bit          outst[2];
  int          acc[2];
  int          mptr;
  bit          rv[2];
  int          g;
  int          k;
  int          n1;
  logic [1:0]  eg, ev;
  logic [31:0] d0, a0, b0;

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    chk_reset_outputs("rst");
    do_reset();

    // Single op: 2.0 * 3.0, accepted in T, result in T+4.
    req_valid = 2'b01;
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'h40400000;
    #1;
    chk("single_ready", req_ready, 2'b01);
    chk("single_idle_t0", idle, 1'b1);
    tick();
    req_valid = 2'b00;
    chk("single_in_valid", mul_in_valid, 1'b1);
    chk("single_op1", mul_op1, 32'h40000000);
    chk("single_op2", mul_op2, 32'h40400000);
    chk("single_idle_t1", idle, 1'b0);
    chk("single_rv_t1", resp_valid, 2'b00);
    tick();
    chk("single_in_valid_t2", mul_in_valid, 1'b0);
    chk("single_rv_t2", resp_valid, 2'b00);
    tick();
    chk("single_rv_t3", resp_valid, 2'b00);
    chk("single_idle_t3", idle, 1'b0);
    tick();
    chk("single_rv_t4", resp_valid, 2'b01);
    chk("single_data", resp_data[31:0], 32'h40C00000);
    chk("single_idle_t4", idle, 1'b0);
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    chk("single_rv_after", resp_valid, 2'b00);
    chk("single_idle_after", idle, 1'b1);

    // Fairness: both always requesting, responses always accepted.
    do_reset();
    req_valid = 2'b11;
    resp_ready = 2'b11;
    req_a = {32'h40000000, 32'h3F800000};
    req_b = {32'h40000000, 32'h3F800000};
    for (int c = 0; c < 15; c++) begin
      #1;
      chk("rr_grant", req_ready, (c % 5 == 0) ? 2'b01 : ((c % 5 == 1) ? 2'b10 : 2'b00));
      tick();
    end

    // Backpressure on requester 0 while requester 1 keeps running.
    do_reset();
    a0 = 32'h40490FDB;
    b0 = 32'h3FC00000;
    req_valid = 2'b01;
    req_a = {32'h40000000, a0};
    req_b = {32'h40800000, b0};
    resp_ready = 2'b10;
    #1;
    chk("bp_first_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b11;
    tick();
    tick();
    tick();
    d0 = fmul_model(a0, b0);
    n1 = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("bp_valid0", resp_valid[0], 1'b1);
      chk("bp_data0", resp_data[31:0], d0);
      chk("bp_ready0", req_ready[0], 1'b0);
      if (req_ready[1]) n1++;
      tick();
    end
    chk("bp_req1_grants", 64'(n1), 64'd4);
    req_valid = 2'b00;
    resp_ready = 2'b11;
    repeat (6) tick();

    // Response handshake and new request on requester 1 in the same cycle.
    do_reset();
    req_valid = 2'b10;
    req_a = {32'h40000000, 32'h0};
    req_b = {32'h40000000, 32'h0};
    #1;
    chk("col_first_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    resp_ready = 2'b10;
    req_valid = 2'b10;
    #1;
    chk("col_rv_same", resp_valid[1], 1'b1);
    chk("col_ready_same", req_ready[1], 1'b0);
    tick();
    resp_ready = 2'b00;
    #1;
    chk("col_rv_next", resp_valid[1], 1'b0);
    chk("col_ready_next", req_ready[1], 1'b1);
    tick();
    req_valid = 2'b00;
    resp_ready = 2'b11;
    repeat (6) tick();

    // Combinational multiplier: result two cycles after acceptance.
    do_reset();
    z_req_valid = 2'b01;
    z_req_a[31:0] = 32'h3FC00000;
    z_req_b[31:0] = 32'h40800000;
    #1;
    chk("lat0_ready", z_req_ready, 2'b01);
    tick();
    z_req_valid = 2'b00;
    chk("lat0_in_valid", z_mul_in_valid, 1'b1);
    chk("lat0_rv_t1", z_resp_valid, 2'b00);
    tick();
    chk("lat0_rv_t2", z_resp_valid, 2'b01);
    chk("lat0_data", z_resp_data[31:0], 32'h40C00000);
    z_resp_ready = 2'b01;
    tick();
    chk("lat0_rv_after", z_resp_valid, 2'b00);
    chk("lat0_idle_after", z_idle, 1'b1);

    // Reset one cycle after issue discards the op and returns ptr to 0.
    do_reset();
    req_valid = 2'b01;
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'h40400000;
    tick();
    req_valid = 2'b00;
    chk("mid_in_valid", mul_in_valid, 1'b1);
    reset = 1'b1;
    tick();
    chk_reset_outputs("mid");
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mid_no_resp", resp_valid, 2'b00);
    end
    req_valid = 2'b11;
    #1;
    chk("mid_first_grant", req_ready, 2'b01);

    // Randomized traffic against the request/response reference model.
    do_reset();
    exp_q0.delete();
    exp_q1.delete();
    outst[0] = 1'b0;
    outst[1] = 1'b0;
    acc[0] = 0;
    acc[1] = 0;
    mptr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid[0]  = ($urandom_range(0, 9) < 6);
      req_valid[1]  = ($urandom_range(0, 9) < 6);
      resp_ready[0] = ($urandom_range(0, 9) < 7);
      resp_ready[1] = ($urandom_range(0, 9) < 7);
      req_a = {rand_fp(), rand_fp()};
      req_b = {rand_fp(), rand_fp()};
      #1;
      rv[0] = req_valid[0];
      rv[1] = req_valid[1];
      g = -1;
      for (int o = 0; o < 2; o++) begin
        k = (mptr + o) % 2;
        if (g < 0 && rv[k] && !outst[k]) g = k;
      end
      eg = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
      ev[0] = outst[0] && (cyc - acc[0] >= LAT + 2);
      ev[1] = outst[1] && (cyc - acc[1] >= LAT + 2);
      chk("rnd_ready", req_ready, eg);
      chk("rnd_resp_valid", resp_valid, ev);
      chk("rnd_idle", idle, !(outst[0] || outst[1]));
      if (ev[0]) chk("rnd_data0", resp_data[31:0], exp_q0[0]);
      if (ev[1]) chk("rnd_data1", resp_data[63:32], exp_q1[0]);
      if (ev[0] && resp_ready[0]) begin
        outst[0] = 1'b0;
        void'(exp_q0.pop_front());
      end
      if (ev[1] && resp_ready[1]) begin
        outst[1] = 1'b0;
        void'(exp_q1.pop_front());
      end
      if (g == 0) begin
        outst[0] = 1'b1;
        acc[0] = cyc;
        exp_q0.push_back(fmul_model(req_a[31:0], req_b[31:0]));
      end else if (g == 1) begin
        outst[1] = 1'b1;
        acc[1] = cyc;
        exp_q1.push_back(fmul_model(req_a[63:32], req_b[63:32]));
      end
      if (g >= 0) mptr = (g + 1) % 2;
      tick();
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
